// File: rtl/fetch_pkg.sv
// Shared WISC fetch/decode types: fetch FSM states, IF/ID payload layout, PC increment.
package fetch_pkg;

  localparam int unsigned WORD_W       = 16;
  localparam logic [3:0]  HALT_OPC_DEF = 4'hF;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus2;
  } ifid_t;

  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(2);
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush forces a bubble, stall holds every field,
// otherwise it loads the offered instruction or bubbles when none is offered.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_instr,
  input  logic [WORD_W-1:0] i_pc,
  input  logic [WORD_W-1:0] i_pc_plus2,
  output logic              o_valid,
  output logic [WORD_W-1:0] o_instr,
  output logic [WORD_W-1:0] o_pc,
  output logic [WORD_W-1:0] o_pc_plus2
);

  ifid_t r_ifid;
  ifid_t w_ifid_next;

  always_comb begin
    w_ifid_next = r_ifid;
    if (i_flush) begin
      w_ifid_next.valid = 1'b0;
    end else if (!i_stall) begin
      if (i_load) begin
        w_ifid_next = '{valid: 1'b1, instr: i_instr, pc: i_pc, pc_plus2: i_pc_plus2};
      end else begin
        w_ifid_next.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifid <= '0;
    end else begin
      r_ifid <= w_ifid_next;
    end
  end

  assign o_valid    = r_ifid.valid;
  assign o_instr    = r_ifid.instr;
  assign o_pc       = r_ifid.pc;
  assign o_pc_plus2 = r_ifid.pc_plus2;

endmodule

// File: rtl/fetch_unit.sv
// WISC instruction fetch: PC, single-outstanding imem requests, 1-entry stall buffer,
// redirect/flush handling. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
  parameter logic [3:0]        HALT_OPC = HALT_OPC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              ifid_valid,
  output logic [WORD_W-1:0] ifid_instr,
  output logic [WORD_W-1:0] ifid_pc,
  output logic [WORD_W-1:0] ifid_pc_plus2,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall_cycles
`endif
);

  fetch_state_t      r_state, w_state_next;
  logic [WORD_W-1:0] r_pc, w_pc_next;
  logic              r_drop, w_drop_next;
  logic              r_buf_valid, w_buf_valid_next;
  logic [WORD_W-1:0] r_buf_instr, r_buf_pc;

  logic              w_handshake;
  logic              w_deliver;
  logic              w_buf_load;
  logic              w_ifid_load;
  logic [WORD_W-1:0] w_redir_pc;
  logic [WORD_W-1:0] w_load_instr, w_load_pc;

  always_comb begin
    imem_req  = ~rst & (r_state == REQ) & ~r_buf_valid;
    imem_addr = r_pc;
    halted    = (r_state == HALT);
  end

  assign w_handshake = imem_req & imem_ready;
  assign w_redir_pc  = redirect_pc & ~WORD_W'(1);
  // A response is only live in WAIT, not marked stale, and not overtaken by a redirect.
  assign w_deliver   = (r_state == WAIT) & imem_rvalid & ~r_drop & ~redirect_valid;
  assign w_buf_load  = w_deliver & stall_in;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_drop_next  = r_drop;
    if (redirect_valid) begin
      w_pc_next = w_redir_pc;
      if (((r_state == WAIT) && !imem_rvalid) || w_handshake) begin
        w_drop_next  = 1'b1;
        w_state_next = WAIT;
      end else begin
        w_drop_next  = 1'b0;
        w_state_next = REQ;
      end
    end else begin
      case (r_state)
        REQ: begin
          if (w_handshake) w_state_next = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (r_drop) begin
              w_drop_next  = 1'b0;
              w_state_next = REQ;
            end else begin
              w_pc_next    = pc_inc(r_pc);
              w_state_next = (imem_rdata[15:12] == HALT_OPC) ? HALT : REQ;
            end
          end
        end
        HALT:    w_state_next = HALT;
        default: w_state_next = REQ;
      endcase
    end
  end

  always_comb begin
    w_buf_valid_next = r_buf_valid;
    if (redirect_valid) begin
      w_buf_valid_next = 1'b0;
    end else if (w_buf_load) begin
      w_buf_valid_next = 1'b1;
    end else if (r_buf_valid && !stall_in) begin
      w_buf_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= REQ;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_instr <= '0;
      r_buf_pc    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_drop      <= w_drop_next;
      r_buf_valid <= w_buf_valid_next;
      if (w_buf_load) begin
        r_buf_instr <= imem_rdata;
        r_buf_pc    <= r_pc;
      end
    end
  end

  // The buffered instruction is older than any new response, so it wins.
  assign w_load_instr = r_buf_valid ? r_buf_instr : imem_rdata;
  assign w_load_pc    = r_buf_valid ? r_buf_pc : r_pc;
  assign w_ifid_load  = r_buf_valid | w_deliver;

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (redirect_valid),
    .i_stall    (stall_in),
    .i_load     (w_ifid_load),
    .i_instr    (w_load_instr),
    .i_pc       (w_load_pc),
    .i_pc_plus2 (pc_inc(w_load_pc)),
    .o_valid    (ifid_valid),
    .o_instr    (ifid_instr),
    .o_pc       (ifid_pc),
    .o_pc_plus2 (ifid_pc_plus2)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_stall;
  logic        w_fetch_evt;

  assign w_fetch_evt = ~redirect_valid & ~stall_in & w_ifid_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_fetch_evt && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 32'd1;
      if ((stall_in || (r_state == WAIT)) && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched      = r_perf_fetched;
  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the perf-counter checks build with FETCH_PERF_CNT_EN.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        ifid_valid;
  logic [15:0] ifid_instr, ifid_pc, ifid_pc_plus2;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall_cycles;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int exp_stall = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus2  (ifid_pc_plus2),
    .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // in_wait: the state the script expects the DUT to be in before this edge.
  task automatic tick(input bit in_wait);
    if (!rst && (stall_in || in_wait)) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", ifid_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_instr", ifid_instr, 0);
    check("rst_pc", ifid_pc, 0);
    check("rst_pcp2", ifid_pc_plus2, 0);
    tick(0);
    tick(0);
    check("rst_req_held", imem_req, 0);
    rst = 1'b0;
    #1;
    check("req_after_rst", imem_req, 1);
    check("addr0", imem_addr, 16'h0000);

    // Basic fetch with 1-cycle memory
    imem_ready = 1; tick(0);
    check("wait_req", imem_req, 0);
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 16'h1234; tick(1);
    check("f1_valid", ifid_valid, 1);
    check("f1_instr", ifid_instr, 16'h1234);
    check("f1_pc", ifid_pc, 16'h0000);
    check("f1_pcp2", ifid_pc_plus2, 16'h0002);
    check("f1_addr", imem_addr, 16'h0002);
    check("f1_req", imem_req, 1);
    imem_rvalid = 0; tick(0);
    check("hold_req", imem_req, 1);
    check("hold_addr", imem_addr, 16'h0002);
    check("bubble", ifid_valid, 0);

    // Stall with buffered response
    imem_ready = 1; tick(0);
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 16'h2222; tick(1);
    check("f2_instr", ifid_instr, 16'h2222);
    check("f2_addr", imem_addr, 16'h0004);
    imem_rvalid = 0; imem_ready = 1; stall_in = 1; tick(0);
    check("st1_valid", ifid_valid, 1);
    check("st1_instr", ifid_instr, 16'h2222);
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 16'h3333; tick(1);
    check("st2_req", imem_req, 0);
    check("st2_instr", ifid_instr, 16'h2222);
    imem_rvalid = 0; tick(0);
    check("st3_req", imem_req, 0);
    check("st3_valid", ifid_valid, 1);
    check("st3_instr", ifid_instr, 16'h2222);
    stall_in = 0; tick(0);
    check("buf_instr", ifid_instr, 16'h3333);
    check("buf_pc", ifid_pc, 16'h0004);
    check("buf_pcp2", ifid_pc_plus2, 16'h0006);
    check("buf_req", imem_req, 1);
    check("buf_addr", imem_addr, 16'h0006);

    // Redirect during WAIT (odd target, bit 0 dropped) while stalled
    imem_ready = 1; stall_in = 1; tick(0);
    check("pre_rd_valid", ifid_valid, 1);
    imem_ready = 0; redirect_valid = 1; redirect_pc = 16'h0041; tick(1);
    check("rd_flush", ifid_valid, 0);
    check("rd_req", imem_req, 0);
    redirect_valid = 0; stall_in = 0; imem_rvalid = 1; imem_rdata = 16'h5555; tick(1);
    check("stale_valid", ifid_valid, 0);
    check("rd_req2", imem_req, 1);
    check("rd_addr", imem_addr, 16'h0040);
    imem_rvalid = 0;

    // Redirect coincident with an accepted request
    imem_ready = 1; redirect_valid = 1; redirect_pc = 16'h0080; tick(0);
    check("rdhs_req", imem_req, 0);
    imem_ready = 0; redirect_valid = 0; imem_rvalid = 1; imem_rdata = 16'h7777; tick(1);
    check("rdhs_valid", ifid_valid, 0);
    check("rdhs_addr", imem_addr, 16'h0080);
    check("rdhs_req2", imem_req, 1);
    imem_rvalid = 0;

    // HALT opcode
    redirect_valid = 1; redirect_pc = 16'h0010; tick(0);
    redirect_valid = 0;
    check("h_addr", imem_addr, 16'h0010);
    imem_ready = 1; tick(0);
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 16'hF000; tick(1);
    check("h_halted", halted, 1);
    check("h_req", imem_req, 0);
    check("h_instr", ifid_instr, 16'hF000);
    check("h_pc", ifid_pc, 16'h0010);
    check("h_pcp2", ifid_pc_plus2, 16'h0012);
    for (int i = 0; i < 10; i++) begin
      imem_ready = 1; imem_rvalid = i[0]; imem_rdata = 16'h1111; tick(0);
      check("h_req_idle", imem_req, 0);
    end
    check("h_still", halted, 1);
    check("h_bubble", ifid_valid, 0);
    imem_ready = 0; imem_rvalid = 0;
    redirect_valid = 1; redirect_pc = 16'h0020; tick(0);
    redirect_valid = 0;
    check("h_clear", halted, 0);
    check("h_req2", imem_req, 1);
    check("h_addr2", imem_addr, 16'h0020);

    // PC wrap
    redirect_valid = 1; redirect_pc = 16'hFFFE; tick(0);
    redirect_valid = 0;
    check("w_addr", imem_addr, 16'hFFFE);
    imem_ready = 1; tick(0);
    imem_ready = 0; imem_rvalid = 1; imem_rdata = 16'h0000; tick(1);
    imem_rvalid = 0;
    check("w_valid", ifid_valid, 1);
    check("w_pc", ifid_pc, 16'hFFFE);
    check("w_pcp2", ifid_pc_plus2, 16'h0000);
    check("w_next_addr", imem_addr, 16'h0000);

`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", perf_fetched, 32'd5);
    check("perf_stall", perf_stall_cycles, 32'(exp_stall));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
